// File: rtl/css128_seq.sv
// css128_seq: sequential N-bit subtractor (d = a - b - bin), one W-bit carry-select slice per cycle.
// Define CSS128_OVF_EN to add the signed-overflow output ovf.
module css128_seq #(
    parameter int unsigned N = 128,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bout,
`ifdef CSS128_OVF_EN
    output logic         ovf,
`endif
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int unsigned NS     = N / W;
    localparam int unsigned GROUPS = W / 4;
    localparam int unsigned CW     = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  a_r;
    logic [N-1:0]  b_r;
    logic [CW-1:0] cnt;
    logic          carry_r;
    int unsigned   base;
    logic [W-1:0]  slice_sum;
    logic          slice_cout;

    assign base = W * 32'(cnt);

    // Current slice: a + ~b + carry as a ripple of 4-bit carry-select groups.
    always_comb begin
        logic [W-1:0] sa;
        logic [W-1:0] sb;
        logic [4:0]   s0;
        logic [4:0]   s1;
        logic         c;
        sa        = a_r[base +: W];
        sb        = ~b_r[base +: W];
        c         = carry_r;
        s0        = '0;
        s1        = '0;
        slice_sum = '0;
        for (int g = 0; g < int'(GROUPS); g++) begin
            s0 = {1'b0, sa[4*g +: 4]} + {1'b0, sb[4*g +: 4]};
            s1 = s0 + 5'd1;
            slice_sum[4*g +: 4] = c ? s1[3:0] : s0[3:0];
            c = c ? s1[4] : s0[4];
        end
        slice_cout = c;
    end

    // Control FSM and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            d         <= '0;
            bout      <= 1'b0;
`ifdef CSS128_OVF_EN
            ovf       <= 1'b0;
`endif
            cnt       <= '0;
            carry_r   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry_r  <= ~bin;
                        cnt      <= '0;
                        d        <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    d[base +: W] <= slice_sum;
                    carry_r      <= slice_cout;
                    if (cnt == LAST) begin
                        bout      <= ~slice_cout;
`ifdef CSS128_OVF_EN
                        ovf       <= (a_r[N-1] != b_r[N-1]) && (slice_sum[W-1] != a_r[N-1]);
`endif
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_css128_seq.sv
// tb_css128_seq: directed bench for css128_seq with an arithmetic reference model and per-cycle compare.
// Build with CSS128_OVF_EN defined to also exercise the ovf output.
module tb_css128_seq;
    localparam int unsigned N  = 128;
    localparam int unsigned W  = 32;
    localparam int unsigned NS = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic [N-1:0] d;
    logic         bout;
    logic         out_valid;
    logic         out_ready;
`ifdef CSS128_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    css128_seq #(.N(N), .W(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .bin(bin),
        .d(d),
        .bout(bout),
`ifdef CSS128_OVF_EN
        .ovf(ovf),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] low_mask(input int bits);
        logic [N-1:0] m;
        for (int i = 0; i < int'(N); i++) m[i] = (i < bits);
        return m;
    endfunction

    // Reference model: whole-word arithmetic, result revealed W bits per edge after accept.
    logic         m_in_ready;
    logic         m_out_valid;
    logic [N-1:0] m_d;
    logic         m_bout;
    logic         m_ovf;
    logic [N-1:0] m_full;
    logic         m_full_bout;
    logic         m_full_ovf;
    logic [N:0]   m_t;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_ready  <= 1'b1;
            m_out_valid <= 1'b0;
            m_d         <= '0;
            m_bout      <= 1'b0;
            m_ovf       <= 1'b0;
            m_left      <= 0;
        end else if (m_in_ready && in_valid) begin
            m_t          = {1'b0, a} - {1'b0, b} - (N+1)'(bin);
            m_full      <= m_t[N-1:0];
            m_full_bout <= m_t[N];
            m_full_ovf  <= (a[N-1] != b[N-1]) && (m_t[N-1] != a[N-1]);
            m_in_ready  <= 1'b0;
            m_d         <= '0;
            m_left      <= int'(NS);
        end else if (m_left > 0) begin
            m_d    <= m_full & low_mask((int'(NS) - m_left + 1) * int'(W));
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_out_valid <= 1'b1;
                m_bout      <= m_full_bout;
                m_ovf       <= m_full_ovf;
            end
        end else if (m_out_valid && out_ready) begin
            m_out_valid <= 1'b0;
            m_in_ready  <= 1'b1;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", N'(in_ready), N'(m_in_ready));
            check("out_valid", N'(out_valid), N'(m_out_valid));
            check("d", d, m_d);
            check("bout", N'(bout), N'(m_bout));
`ifdef CSS128_OVF_EN
            check("ovf", N'(ovf), N'(m_ovf));
`endif
        end
    end

    task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b, input logic op_bin,
                          output int lat);
        int guard;
        @(negedge clk);
        a        = op_a;
        b        = op_b;
        bin      = op_bin;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", N'(guard < 50), N'(1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Handshake the result while offering operands that must not be taken this cycle.
    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = '1;
        b         = '0;
        bin       = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("in_ready_after_release", N'(in_ready), N'(1));
    endtask

    initial begin
        int           lat;
        logic [N-1:0] held_d;
        logic         held_bout;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        #12;
        check("rst_in_ready", N'(in_ready), N'(1));
        check("rst_out_valid", N'(out_valid), N'(0));
        check("rst_d", d, '0);
        check("rst_bout", N'(bout), N'(0));
        @(negedge clk);
        #2 rst = 1'b0;

        // 5 - 3
        run_op(N'(5), N'(3), 1'b0, lat);
        check("lat_5_3", N'(lat), N'(4));
        check("d_5_3", d, N'(2));
        check("bout_5_3", N'(bout), N'(0));
        release_result();
        check("d_kept_idle", d, N'(2));

        // 0 - 1 wraps to all ones with borrow
        run_op(N'(0), N'(1), 1'b0, lat);
        check("lat_0_1", N'(lat), N'(4));
        check("d_0_1", d, {N{1'b1}});
        check("bout_0_1", N'(bout), N'(1));
        release_result();

        // Borrow crossing slice 0 into slice 1
        run_op(N'(1) << 32, N'(0), 1'b1, lat);
        check("d_cross", d, N'(32'hFFFF_FFFF));
        check("bout_cross", N'(bout), N'(0));
        release_result();

        // Equal operands with borrow-in
        run_op({4{32'hDEAD_BEEF}}, {4{32'hDEAD_BEEF}}, 1'b1, lat);
        check("d_eq_bin", d, {N{1'b1}});
        check("bout_eq_bin", N'(bout), N'(1));
        release_result();

        // Stall in DONE while new operands are presented
        run_op({N{1'b1}}, N'(1), 1'b0, lat);
        held_d    = d;
        held_bout = bout;
        check("d_max_minus1", d, {{(N-1){1'b1}}, 1'b0});
        for (int i = 0; i < 10; i++) begin
            a        = N'(i * 7 + 1);
            b        = N'(i);
            bin      = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            check("hold_d", d, held_d);
            check("hold_bout", N'(bout), N'(held_bout));
            check("hold_out_valid", N'(out_valid), N'(1));
            check("hold_in_ready", N'(in_ready), N'(0));
        end
        in_valid = 1'b0;
        release_result();

        // Asynchronous reset while slice 2 is pending
        @(negedge clk);
        a        = {4{32'h1234_5678}};
        b        = {4{32'h0FED_CBA9}};
        bin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", N'(out_valid), N'(0));
        check("mid_rst_in_ready", N'(in_ready), N'(1));
        check("mid_rst_d", d, '0);
        #1 rst = 1'b0;
        run_op({4{32'h1234_5678}}, {4{32'h0FED_CBA9}}, 1'b0, lat);
        check("lat_after_rst", N'(lat), N'(4));
        check("d_after_rst", d, {4{32'h0246_8ACF}});
        check("bout_after_rst", N'(bout), N'(0));
        release_result();

        // Most negative minus one
        run_op({1'b1, {(N-1){1'b0}}}, N'(1), 1'b0, lat);
        check("d_min_minus1", d, {1'b0, {(N-1){1'b1}}});
        check("bout_min_minus1", N'(bout), N'(0));
`ifdef CSS128_OVF_EN
        check("ovf_min_minus1", N'(ovf), N'(1));
`endif
        release_result();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/css128_seq.md
CSS128_SEQ -- requirements
Module: css128_seq

Interface
REQ-001 SHALL have parameter N, default 128, meaning operand/result width in bits.
REQ-002 SHALL have parameter W, default 32, meaning slice width processed per cycle; N SHALL be an integer multiple of W, and W SHALL be a multiple of 4.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, bin present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  N  minuend.
REQ-008 SHALL have port b  input  N  subtrahend.
REQ-009 SHALL have port bin  input  1  borrow-in.
REQ-010 SHALL have port d  output  N  difference a - b - bin, modulo 2^N.
REQ-011 SHALL have port bout  output  1  borrow-out: 1 when unsigned a < b + bin.
REQ-012 SHALL have port out_valid  output  1  d/bout hold a completed result.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the result.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL assert in_ready only in IDLE; in_valid SHALL be ignored in RUN and DONE.
REQ-016 SHALL, on an edge where in_valid && in_ready, register a, b, and bin, clear the slice counter, and enter RUN.
REQ-017 SHALL, in RUN, compute one W-bit slice per cycle, LSB slice first.
REQ-018 SHALL compute each slice as a + ~b + carry, using 4-bit carry-select groups; the carry into slice 0 SHALL be ~bin, and the carry into slice k SHALL be the registered carry-out of slice k-1.
REQ-019 SHALL write slice k of d on RUN cycle k; slices not yet computed SHALL read 0.
REQ-020 SHALL leave RUN for DONE on the edge that computes slice N/W-1, and SHALL set out_valid there; latency is N/W edges from accept (4 at defaults).
REQ-021 SHALL set bout to the inverse of the final slice carry-out.
REQ-022 SHALL hold d, bout, and out_valid stable in DONE until out_valid && out_ready.
REQ-023 SHALL, on out_valid && out_ready, clear out_valid and enter IDLE; in_ready SHALL rise on the following cycle (no same-cycle reaccept).
REQ-024 SHALL not change d or bout in IDLE; the last result remains visible with out_valid=0.

Reset
REQ-025 SHALL, while rst=1, immediately force state=IDLE, in_ready=1, out_valid=0, d=0, bout=0, and counter=0, regardless of clk.
REQ-026 SHALL discard any operation in progress when reset occurs mid-RUN or in DONE; no partial result SHALL be flagged valid.

Configuration
REQ-027 SHALL, when macro CSS128_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow, set with out_valid, defined as (a[N-1] != b[N-1]) && (d[N-1] != a[N-1]), reset 0, and held like d.
REQ-028 SHALL, when CSS128_OVF_EN is not defined, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: a=5, b=3, bin=0 -> d=2, bout=0, out_valid exactly 4 edges after accept.
REQ-030 SHALL cover: a=0, b=1, bin=0 -> d=2^128-1 (all ones), bout=1.
REQ-031 SHALL cover: a=0x1_0000_0000, b=0, bin=1 -> d=0xFFFF_FFFF, bout=0 (borrow crosses slice 0 -> 1).
REQ-032 SHALL cover: result in DONE, out_ready=0 for 10 cycles, in_valid=1 with new operands -> d/bout/out_valid stable, in_ready=0, new operands not taken.
REQ-033 SHALL cover: rst pulsed asynchronously during RUN slice 2 -> out_valid=0, in_ready=1, d=0 immediately; next accept computes correctly.
REQ-034 SHALL cover, with CSS128_OVF_EN: a=0x8000...0, b=1, bin=0 -> d=0x7FFF...F, ovf=1, bout=0.
